game_ctrl: RTL
==============

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter SERVE_FRAMES, default 60: frames the object is held parked before each serve.
REQ-002 SHALL have parameter RESTART_PAUSE, default 128: frames in GAMEOVER before fire is accepted.
REQ-003 SHALL have parameter LIVES, default 3, legal range 1..7: lives granted per game.
REQ-004 SHALL have parameter SCORE_W, default 8: score counter width.
REQ-005 SHALL have port clk  in  1  pixel clock; the block's only clock.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port frame_tick  in  1  one-cycle pulse once per frame (start of vblank).
REQ-008 SHALL have port btn_fire  in  1  fire button level, already synchronized and debounced.
REQ-009 SHALL have port obj_hit  in  1  one-cycle pulse: object bounced off paddle.
REQ-010 SHALL have port obj_miss  in  1  one-cycle pulse: object passed paddle.
REQ-011 SHALL have port play_en  out  1  high in PLAY; enables paddle and object motion.
REQ-012 SHALL have port obj_respawn  out  1  one-cycle pulse: object returns to its serve position.
REQ-013 SHALL have port gameover_en  out  1  high in GAMEOVER; enables the game-over text overlay.
REQ-014 SHALL have port score  out  SCORE_W  current score.
REQ-015 SHALL have port lives  out  3  remaining lives.

Function
REQ-016 SHALL implement a registered FSM with states IDLE, SERVE, PLAY and GAMEOVER.
REQ-017 SHALL detect a fire edge (fire_rise) as btn_fire=1 while the registered previous btn_fire=0; a held button SHALL NOT produce repeated edges.
REQ-018 In IDLE, on fire_rise SHALL go to SERVE, load score=0 and lives=LIVES, and pulse obj_respawn.
REQ-019 In SERVE, SHALL count frame_tick pulses from a counter cleared on entry, and SHALL go to PLAY in the cycle after the SERVE_FRAMES-th tick; a tick in the entry cycle itself SHALL NOT be counted.
REQ-020 In PLAY, obj_hit SHALL increment score by 1, saturating at 2^SCORE_W-1.
REQ-021 In PLAY, obj_miss with lives>1 SHALL decrement lives, go to SERVE, and pulse obj_respawn.
REQ-022 In PLAY, obj_miss with lives==1 SHALL set lives=0 and go to GAMEOVER.
REQ-023 In PLAY, obj_hit and obj_miss in the same cycle SHALL be handled as a miss only; score SHALL be unchanged.
REQ-024 obj_hit and obj_miss SHALL be ignored in any state other than PLAY.
REQ-025 In GAMEOVER, SHALL count frame_tick pulses from a counter cleared on entry, and SHALL ignore fire until RESTART_PAUSE ticks have been counted.
REQ-026 In GAMEOVER after the pause, fire_rise SHALL go to SERVE, reload score=0 and lives=LIVES, and pulse obj_respawn; score SHALL hold its final value until then.
REQ-027 A button held continuously from PLAY through the end of the pause SHALL NOT restart the game; a release and a new press SHALL be required.
REQ-028 The frame counter SHALL be wide enough for max(SERVE_FRAMES, RESTART_PAUSE) and SHALL NOT wrap; it SHALL hold at terminal count.
REQ-029 All outputs SHALL be registered; play_en, gameover_en, score and lives SHALL reflect an event in the cycle after the event's input cycle.
REQ-030 obj_respawn SHALL be exactly one cycle wide, asserted in the first cycle the state register reads SERVE.
REQ-031 play_en and gameover_en SHALL never be high simultaneously.

Reset
REQ-032 While rst=1, SHALL force state=IDLE, play_en=0, obj_respawn=0, gameover_en=0, score=0, lives=0, frame counter=0 and previous-fire register=0.
REQ-033 A reset asserted mid-game, in any state, SHALL take effect on the next clk edge, with no pending pulse emitted after release.
REQ-034 A btn_fire already high when rst deasserts SHALL NOT be taken as fire_rise.

Verification
REQ-035 Start: rst, release, fire pulse -> obj_respawn one cycle, lives=3, score=0; play_en rises the cycle after the 60th frame_tick.
REQ-036 Scoring: 300 obj_hit pulses in PLAY with SCORE_W=8 -> score saturates at 255.
REQ-037 Lives: three obj_miss pulses, each after re-serve -> lives 2, 1, 0; state GAMEOVER, gameover_en=1, play_en=0.
REQ-038 Simultaneous: obj_hit+obj_miss in the same cycle at score=5, lives=2 -> score=5, lives=1, obj_respawn pulse.
REQ-039 Restart pause: fire pressed at the 100th GAMEOVER tick -> ignored; fire held through tick 128 -> no restart; release and press -> SERVE, score=0, lives=3.
REQ-040 Reset mid-PLAY: rst for one cycle -> IDLE, all outputs 0 on the next cycle.

Source files
------------

// File: rtl/game_ctrl.sv
// Game flow controller: sequences idle, serve, play and game-over phases,
// and keeps the score and the remaining lives.
module game_ctrl #(
  parameter int SERVE_FRAMES  = 60,
  parameter int RESTART_PAUSE = 128,
  parameter int LIVES         = 3,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               btn_fire,
  input  logic               obj_hit,
  input  logic               obj_miss,
  output logic               play_en,
  output logic               obj_respawn,
  output logic               gameover_en,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives
);

  localparam int CNT_MAX = (SERVE_FRAMES > RESTART_PAUSE) ? SERVE_FRAMES : RESTART_PAUSE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   CNT_TOP    = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   PAUSE_CNT  = CNT_W'(RESTART_PAUSE);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, GAMEOVER} state_t;

  state_t             state, state_nxt;
  logic               prev_fire;
  logic               fire_armed;
  logic [CNT_W-1:0]   frame_cnt, cnt_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic [2:0]         lives_nxt;
  logic               fire_rise;
  logic               cnt_can_inc;

  // fire_armed stays low until the button is seen released after reset,
  // so a press held through reset never counts as an edge.
  assign fire_rise   = btn_fire & ~prev_fire & fire_armed;
  assign cnt_can_inc = frame_tick && (frame_cnt != CNT_TOP);

  always_comb begin
    state_nxt = state;
    score_nxt = score;
    lives_nxt = lives;
    cnt_nxt   = frame_cnt;
    case (state)
      IDLE: begin
        if (fire_rise) begin
          state_nxt = SERVE;
          score_nxt = '0;
          lives_nxt = LIVES_INIT;
          cnt_nxt   = '0;
        end
      end
      SERVE: begin
        // obj_respawn marks the entry cycle, whose tick is not counted
        if (frame_tick && !obj_respawn) begin
          if (frame_cnt == SERVE_LAST) begin
            state_nxt = PLAY;
            cnt_nxt   = '0;
          end else if (cnt_can_inc) begin
            cnt_nxt = frame_cnt + CNT_W'(1);
          end
        end
      end
      PLAY: begin
        if (obj_miss) begin
          cnt_nxt = '0;
          if (lives > 3'd1) begin
            lives_nxt = lives - 3'd1;
            state_nxt = SERVE;
          end else begin
            lives_nxt = 3'd0;
            state_nxt = GAMEOVER;
          end
        end else if (obj_hit && (score != SCORE_MAX)) begin
          score_nxt = score + SCORE_W'(1);
        end
      end
      GAMEOVER: begin
        if ((frame_cnt >= PAUSE_CNT) && fire_rise) begin
          state_nxt = SERVE;
          score_nxt = '0;
          lives_nxt = LIVES_INIT;
          cnt_nxt   = '0;
        end else if (cnt_can_inc) begin
          cnt_nxt = frame_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prev_fire   <= 1'b0;
      fire_armed  <= 1'b0;
      frame_cnt   <= '0;
      score       <= '0;
      lives       <= 3'd0;
      play_en     <= 1'b0;
      gameover_en <= 1'b0;
      obj_respawn <= 1'b0;
    end else begin
      state       <= state_nxt;
      prev_fire   <= btn_fire;
      if (!btn_fire) fire_armed <= 1'b1;
      frame_cnt   <= cnt_nxt;
      score       <= score_nxt;
      lives       <= lives_nxt;
      play_en     <= (state_nxt == PLAY);
      gameover_en <= (state_nxt == GAMEOVER);
      obj_respawn <= (state_nxt == SERVE) && (state != SERVE);
    end
  end

endmodule
